tmcu_apb_arb: RTL

TMCU_APB_ARB -- requirements
Module: tmcu_apb_arb

---
 rtl/tmcu_apb_pkg.sv | 15 +
 rtl/tmcu_apb_arb_if.sv | 37 +++
 rtl/tmcu_rr_arbiter.sv | 26 ++
 rtl/tmcu_apb_arb.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tmcu_apb_pkg.sv
// Shared types and constants for the tmcu APB arbiter: FSM state encoding,
// APB bus widths and the default access timeout.
package tmcu_apb_pkg;

  localparam int APB_ADDR_W          = 32;
  localparam int APB_DATA_W          = 32;
  localparam int DEFAULT_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/tmcu_apb_arb_if.sv
// Requester and APB peripheral signals of the arbiter. The arbiter uses the
// slave modport; the requesters/peripheral side uses the master modport.
interface tmcu_apb_arb_if #(
  parameter int NUM_REQ = 2
);
  import tmcu_apb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [APB_DATA_W-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [APB_ADDR_W-1:0]         paddr;
  logic [APB_DATA_W-1:0]         pwdata;
  logic [APB_DATA_W-1:0]         prdata;
  logic                          pready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/tmcu_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1
// (wrapping) and returns a one-hot grant of the first active request.
module tmcu_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant
);

  int w_idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    o_grant = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (i_req[w_idx] && (o_grant == '0)) begin
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmcu_apb_arb.sv
// N-to-1 round-robin arbiter driving a single APB peripheral port.
// Define TMCU_APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module tmcu_apb_arb
  import tmcu_apb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input logic              clk,
  input logic              rst,
  tmcu_apb_arb_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_state_e              r_state;
  apb_state_e              w_next_state;
  logic [IDX_W-1:0]        r_last_grant;
  logic [NUM_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_win_write;
  logic [APB_ADDR_W-1:0]   w_win_addr;
  logic [APB_DATA_W-1:0]   w_win_wdata;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_timeout;
  logic                    w_finish;
  logic                    r_pwrite;
  logic [APB_ADDR_W-1:0]   r_paddr;
  logic [APB_DATA_W-1:0]   r_pwdata;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [APB_DATA_W-1:0]   r_rsp_rdata;

  tmcu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Mux the winner's request fields out of the packed vectors.
  always_comb begin
    w_win_idx   = '0;
    w_win_write = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx   = IDX_W'(i);
        w_win_write = bus.req_write[i];
        w_win_addr  = bus.req_addr[i*APB_ADDR_W +: APB_ADDR_W];
        w_win_wdata = bus.req_wdata[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && (|bus.req_valid);
  assign w_done   = (r_state == ST_ACCESS) && bus.pready;
  assign w_finish = w_done || w_timeout;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (w_finish) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_win_idx;
        r_pwrite     <= w_win_write;
        r_paddr      <= w_win_addr;
        r_pwdata     <= w_win_wdata;
      end
      // r_last_grant doubles as the owner of the transfer in flight.
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= w_finish && (r_last_grant == IDX_W'(i));
      end
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
      end
    end
  end

`ifdef TMCU_APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_timeout;
      if ((r_state == ST_ACCESS) && !bus.pready) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign w_timeout   = (r_state == ST_ACCESS) && !bus.pready &&
                       (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.rsp_err = r_rsp_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Decoding psel/penable from state lets reset drop them asynchronously.
  assign bus.req_ready = w_accept ? w_grant : '0;
  assign bus.psel      = (r_state != ST_IDLE);
  assign bus.penable   = (r_state == ST_ACCESS);
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule
